// File: rtl/serial_word_loader_if.sv
// Handshake and data bundle between the serial word loader and its neighbours.
// The master side drives frame/serial/ack inputs; the slave side is the loader itself.
interface serial_word_loader_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             sen;
    logic             sin;
    logic             ack;
    logic [WIDTH-1:0] d_out;
    logic             load;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    modport master (
        output start, sen, sin, ack,
        input  d_out, load, busy, overrun, parity_err
    );

    modport slave (
        input  start, sen, sin, ack,
        output d_out, load, busy, overrun, parity_err
    );
endinterface

// File: rtl/serial_word_loader.sv
// Assembles a serial bit stream into WIDTH-bit words and offers them with a load/ack handshake.
// Optional macro PARITY_CHECK_EN adds a trailing even-parity bit and drives parity_err.
//
//   state  | meaning
//   IDLE   | waiting for start; sen/sin ignored
//   SHIFT  | sampling data bits on sen cycles
//   PARITY | sampling the parity bit (PARITY_CHECK_EN only)
module serial_word_loader #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  clr,
    serial_word_loader_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic             load_q, load_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             complete;
`ifdef PARITY_CHECK_EN
    logic             parity_err_q, parity_err_d;
    logic             pbit;
`endif

    // The first sampled bit walks towards the MSB or the LSB depending on bit order.
    assign shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], bus.sin}
                               : {bus.sin, sreg_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sreg_q       <= '0;
            d_out_q      <= '0;
            load_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sreg_q       <= sreg_d;
            d_out_q      <= d_out_d;
            load_q       <= load_d;
            overrun_q    <= overrun_d;
`ifdef PARITY_CHECK_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sreg_d       = sreg_q;
        d_out_d      = d_out_q;
        load_d       = load_q;
        overrun_d    = overrun_q;
        word         = sreg_q;
        complete     = 1'b0;
`ifdef PARITY_CHECK_EN
        parity_err_d = parity_err_q;
        pbit         = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sreg_d  = '0;
                end
            end
            SHIFT: begin
                // Restart takes priority over a coincident serial bit.
                if (bus.start) begin
                    cnt_d  = '0;
                    sreg_d = '0;
                end else if (bus.sen) begin
                    sreg_d = shifted;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d = '0;
`ifdef PARITY_CHECK_EN
                        state_d = PARITY;
`else
                        state_d  = IDLE;
                        complete = 1'b1;
                        word     = shifted;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sreg_d  = '0;
                end else if (bus.sen) begin
                    state_d  = IDLE;
                    complete = 1'b1;
                    word     = sreg_q;
                    pbit     = bus.sin;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (load_q && bus.ack) begin
            load_d = 1'b0;
        end

        // An ack on the completion edge frees the buffer in time for the new word.
        if (complete) begin
            if (!load_q || bus.ack) begin
                d_out_d = word;
                load_d  = 1'b1;
`ifdef PARITY_CHECK_EN
                parity_err_d = (^word) ^ pbit;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign bus.d_out   = d_out_q;
    assign bus.load    = load_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.overrun = overrun_q;
`ifdef PARITY_CHECK_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial_word_loader.sv
// Bench for serial_word_loader: directed scenarios plus random traffic against a frame-level model.
module tb_serial_word_loader;
    localparam int WIDTH     = 4;
    localparam bit MSB_FIRST = 1'b1;
`ifdef PARITY_CHECK_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    serial_word_loader_if #(.WIDTH(WIDTH)) bus ();

    serial_word_loader #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: frame-level view using a queue of received bits
    bit               m_active;
    int               mq[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_load;
    logic             m_ovr;
    logic             m_perr;

    task automatic model_reset();
        m_active = 1'b0;
        mq.delete();
        m_dout = '0;
        m_load = 1'b0;
        m_ovr  = 1'b0;
        m_perr = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic e, input logic b, input logic a);
        bit done = 1'b0;
        int w    = 0;
        int ones = 0;
        bit pe   = 1'b0;
        if (s) begin
            m_active = 1'b1;
            mq.delete();
        end else if (m_active && e) begin
            mq.push_back(int'(b));
            if (mq.size() == NBITS) begin
                for (int i = 0; i < WIDTH; i++) begin
                    w    = w + (mq[i] << (MSB_FIRST ? (WIDTH - 1 - i) : i));
                    ones = ones + mq[i];
                end
`ifdef PARITY_CHECK_EN
                pe = bit'((ones + mq[WIDTH]) % 2);
`endif
                done     = 1'b1;
                m_active = 1'b0;
                mq.delete();
            end
        end
        if (done) begin
            if (!m_load || a) begin
                m_dout = w[WIDTH-1:0];
                m_load = 1'b1;
                m_perr = pe;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_load && a) begin
            m_load = 1'b0;
        end
    endtask

    task automatic step(input logic s, input logic e, input logic b, input logic a);
        @(negedge clk);
        bus.start = s;
        bus.sen   = e;
        bus.sin   = b;
        bus.ack   = a;
        @(posedge clk);
        model_edge(s, e, b, a);
        #1;
    endtask

    // Sends word w first-bit-first (w[WIDTH-1] first), with correct even parity when enabled.
    task automatic send_word(input logic [WIDTH-1:0] w, input logic ack_last);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH; i++)
            step(1'b0, 1'b1, w[WIDTH-1-i], (i == WIDTH - 1 && NBITS == WIDTH) ? ack_last : 1'b0);
`ifdef PARITY_CHECK_EN
        step(1'b0, 1'b1, ^w, ack_last);
`endif
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.sen = 1'b0; bus.sin = 1'b0; bus.ack = 1'b0;
        clr = 1'b1;
        model_reset();
        #100;
        clr = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.d_out !== '0 || bus.load !== 1'b0 || bus.busy !== 1'b0 ||
            bus.overrun !== 1'b0 || bus.parity_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: d_out=%b load=%b busy=%b ovr=%b perr=%b, required all 0",
                     bus.d_out, bus.load, bus.busy, bus.overrun, bus.parity_err);
        end
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] exp_word = 4'b1011;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy: busy=%b required 1", bus.busy);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (bus.load !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_early_load: load=%b required 0", bus.load);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0);
`ifdef PARITY_CHECK_EN
        step(1'b0, 1'b1, 1'b1, 1'b0);
`endif
        vectors++;
        if (bus.load !== 1'b1 || bus.d_out !== exp_word || bus.d_out !== m_dout || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_word: load=%b d_out=%b busy=%b, required load=1 d_out=%b busy=0",
                     bus.load, bus.d_out, bus.busy, exp_word);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (bus.load !== 1'b0 || bus.d_out !== exp_word) begin
            miscompares++;
            $display("FAIL basic_ack: load=%b d_out=%b, required load=0 d_out=%b",
                     bus.load, bus.d_out, exp_word);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (bus.load !== m_load || bus.d_out !== m_dout) begin
            miscompares++;
            $display("FAIL basic_idle_ack: load=%b d_out=%b, required load=%b d_out=%b",
                     bus.load, bus.d_out, m_load, m_dout);
        end
    endtask

    task automatic test_overrun();
        send_word(4'b1001, 1'b0);
        send_word(4'b1101, 1'b0);
        vectors++;
        if (bus.d_out !== 4'b1001 || bus.overrun !== 1'b1 || bus.load !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun: d_out=%b ovr=%b load=%b, required 1001 1 1",
                     bus.d_out, bus.overrun, bus.load);
        end
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (bus.overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky: ovr=%b required 1", bus.overrun);
        end
    endtask

    task automatic test_ack_on_completion();
        send_word(4'b1111, 1'b1);
        vectors++;
        if (bus.d_out !== 4'b1111 || bus.load !== 1'b1 || bus.overrun !== 1'b1 || bus.d_out !== m_dout) begin
            miscompares++;
            $display("FAIL ack_on_completion: d_out=%b load=%b ovr=%b, required 1111 1 1",
                     bus.d_out, bus.load, bus.overrun);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (bus.load !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_release: load=%b required 0", bus.load);
        end
    endtask

    task automatic test_restart();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        // start coinciding with sen: that bit must not be sampled
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
`ifdef PARITY_CHECK_EN
        step(1'b0, 1'b1, 1'b1, 1'b0);
`endif
        vectors++;
        if (bus.d_out !== 4'b1101 || bus.load !== 1'b1) begin
            miscompares++;
            $display("FAIL restart: d_out=%b load=%b, required 1101 1", bus.d_out, bus.load);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        clr = 1'b1;
        model_reset();
        #2;
        vectors++;
        if (bus.busy !== 1'b0 || bus.load !== 1'b0 || bus.overrun !== 1'b0 || bus.d_out !== '0) begin
            miscompares++;
            $display("FAIL clr_midframe: busy=%b load=%b ovr=%b d_out=%b, required all 0",
                     bus.busy, bus.load, bus.overrun, bus.d_out);
        end
        @(negedge clk);
        clr = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (bus.load !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_discard: load=%b busy=%b, required 0 0", bus.load, bus.busy);
        end
    endtask

    task automatic test_parity();
`ifdef PARITY_CHECK_EN
        send_word(4'b1011, 1'b0);
        vectors++;
        if (bus.parity_err !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_good: parity_err=%b required 0", bus.parity_err);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (bus.parity_err !== 1'b1 || bus.d_out !== 4'b1011) begin
            miscompares++;
            $display("FAIL parity_bad: parity_err=%b d_out=%b required 1 1011",
                     bus.parity_err, bus.d_out);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
`else
        send_word(4'b0111, 1'b0);
        vectors++;
        if (bus.parity_err !== 1'b0 || bus.d_out !== 4'b0111) begin
            miscompares++;
            $display("FAIL parity_tied: parity_err=%b d_out=%b required 0 0111",
                     bus.parity_err, bus.d_out);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom), ($urandom_range(0, 4) == 0));
            vectors++;
            if (bus.d_out !== m_dout || bus.load !== m_load || bus.busy !== m_active ||
                bus.overrun !== m_ovr || bus.parity_err !== m_perr) begin
                miscompares++;
                $display("FAIL random[%0d]: d_out=%b load=%b busy=%b ovr=%b perr=%b, required %b %b %b %b %b",
                         n, bus.d_out, bus.load, bus.busy, bus.overrun, bus.parity_err,
                         m_dout, m_load, m_active, m_ovr, m_perr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_ack_on_completion();
        test_restart();
        test_parity();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
